// File: rtl/receiver_event_arbiter.sv
// receiver_event_arbiter
// Serialises decoded sweep events from NB_RECEIVERS receiver managers onto a
// single valid/ready stream. Each channel has one holding slot. Channels are
// served round-robin, and a per-channel overrun flag is set and held whenever a
// held event is overwritten before it could be sent.
module receiver_event_arbiter #(
  parameter int NB_RECEIVERS = 4,
  parameter int DATA_WIDTH   = 17,
  parameter int TS_WIDTH     = 24,
  parameter int ID_WIDTH     = 2
) (
  input  logic                             clk_96MHz,
  input  logic                             reset,
  input  logic [NB_RECEIVERS-1:0]          data_availible,
  input  logic [NB_RECEIVERS*DATA_WIDTH-1:0] decoded_data,
  input  logic [NB_RECEIVERS*TS_WIDTH-1:0] timestamp_in,
  input  logic                             out_ready,
  input  logic                             clear_overrun,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [TS_WIDTH-1:0]              out_timestamp,
  output logic [ID_WIDTH-1:0]              out_sensor_id,
  output logic [NB_RECEIVERS-1:0]          overrun_flags
);

  logic [NB_RECEIVERS-1:0] prev_q, prev_d;
  logic [NB_RECEIVERS-1:0] pending_q, pending_d;
  logic [NB_RECEIVERS-1:0] overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]   hold_data_q [NB_RECEIVERS];
  logic [DATA_WIDTH-1:0]   hold_data_d [NB_RECEIVERS];
  logic [TS_WIDTH-1:0]     hold_ts_q   [NB_RECEIVERS];
  logic [TS_WIDTH-1:0]     hold_ts_d   [NB_RECEIVERS];
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [TS_WIDTH-1:0]     out_ts_q, out_ts_d;
  logic [ID_WIDTH-1:0]     out_id_q, out_id_d;

  logic [NB_RECEIVERS-1:0] capture;
  logic                    slot_free;
  logic                    any_pending;
  logic                    grant;
  logic [ID_WIDTH-1:0]     winner;
  logic [ID_WIDTH-1:0]     search_idx;

  // Edge detect, round-robin search starting after the last winner, and grant decision
  always_comb begin
    capture     = data_availible & ~prev_q;
    slot_free   = !out_valid_q || out_ready;
    any_pending = 1'b0;
    winner      = '0;
    search_idx  = '0;
    for (int k = 1; k <= NB_RECEIVERS; k++) begin
      search_idx = ID_WIDTH'((int'(ptr_q) + k) % NB_RECEIVERS);
      if (!any_pending && pending_q[search_idx]) begin
        any_pending = 1'b1;
        winner      = search_idx;
      end
    end
    grant = slot_free && any_pending;
  end

  // Next-state for holding slots, pending/overrun bits and the output register
  always_comb begin
    prev_d      = data_availible;
    pending_d   = pending_q;
    overrun_d   = clear_overrun ? '0 : overrun_q;
    hold_data_d = hold_data_q;
    hold_ts_d   = hold_ts_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ts_d    = out_ts_q;
    out_id_d    = out_id_q;

    if (grant) begin
      out_valid_d       = 1'b1;
      out_data_d        = hold_data_q[winner];
      out_ts_d          = hold_ts_q[winner];
      out_id_d          = winner;
      ptr_d             = winner;
      pending_d[winner] = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A capture on the channel being granted this edge is not an overrun:
    // the old word leaves via the output and the new one takes the slot.
    for (int i = 0; i < NB_RECEIVERS; i++) begin
      if (capture[i]) begin
        hold_data_d[i] = decoded_data[i*DATA_WIDTH +: DATA_WIDTH];
        hold_ts_d[i]   = timestamp_in[i*TS_WIDTH +: TS_WIDTH];
        pending_d[i]   = 1'b1;
        if (pending_q[i] && !(grant && (winner == ID_WIDTH'(i)))) begin
          overrun_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      prev_q      <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      ptr_q       <= ID_WIDTH'(NB_RECEIVERS - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ts_q    <= '0;
      out_id_q    <= '0;
      for (int i = 0; i < NB_RECEIVERS; i++) begin
        hold_data_q[i] <= '0;
        hold_ts_q[i]   <= '0;
      end
    end else begin
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ts_q    <= out_ts_d;
      out_id_q    <= out_id_d;
      for (int i = 0; i < NB_RECEIVERS; i++) begin
        hold_data_q[i] <= hold_data_d[i];
        hold_ts_q[i]   <= hold_ts_d[i];
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_timestamp = out_ts_q;
  assign out_sensor_id = out_id_q;
  assign overrun_flags = overrun_q;

endmodule

// File: tb/tb_receiver_event_arbiter.sv
// Directed bench for receiver_event_arbiter: a vector table for the
// round-robin burst plus hand-written sequences for the multi-cycle cases.
module tb_receiver_event_arbiter;

  localparam int N  = 4;
  localparam int DW = 17;
  localparam int TW = 24;
  localparam int IW = 2;

  logic            clk_96MHz = 1'b0;
  logic            reset;
  logic [N-1:0]    data_availible;
  logic [N*DW-1:0] decoded_data;
  logic [N*TW-1:0] timestamp_in;
  logic            out_ready;
  logic            clear_overrun;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [TW-1:0]   out_timestamp;
  logic [IW-1:0]   out_sensor_id;
  logic [N-1:0]    overrun_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]  da;
    logic          rdy;
    logic          exp_valid;
    logic [IW-1:0] exp_id;
  } vec_t;

  vec_t tbl[12];

  receiver_event_arbiter #(
    .NB_RECEIVERS(N), .DATA_WIDTH(DW), .TS_WIDTH(TW), .ID_WIDTH(IW)
  ) dut (
    .clk_96MHz      (clk_96MHz),
    .reset          (reset),
    .data_availible (data_availible),
    .decoded_data   (decoded_data),
    .timestamp_in   (timestamp_in),
    .out_ready      (out_ready),
    .clear_overrun  (clear_overrun),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_timestamp  (out_timestamp),
    .out_sensor_id  (out_sensor_id),
    .overrun_flags  (overrun_flags)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full cycle: active edge, then settle to the sampling (falling) edge.
  task automatic tick();
    @(posedge clk_96MHz);
    @(negedge clk_96MHz);
  endtask

  function automatic logic [DW-1:0] def_data(input int ch);
    return DW'(17'h00100 + ch);
  endfunction

  function automatic logic [TW-1:0] def_ts(input int ch);
    return TW'(24'h00A000 + ch);
  endfunction

  task automatic set_defaults();
    for (int i = 0; i < N; i++) begin
      decoded_data[i*DW +: DW] = def_data(i);
      timestamp_in[i*TW +: TW] = def_ts(i);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    data_availible = '0;
    clear_overrun  = 1'b0;
    out_ready      = 1'b1;
    set_defaults();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [DW-1:0] frozen_data;
    logic [TW-1:0] frozen_ts;

    // Round-robin burst: pointer starts at 3 after reset, so 0,1,2,3 then
    // the pointer sits at 3 again and the second burst also runs 0,1,2,3.
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0};
    tbl[1]  = '{4'b0000, 1'b1, 1'b1, 2'd0};
    tbl[2]  = '{4'b0000, 1'b1, 1'b1, 2'd1};
    tbl[3]  = '{4'b0000, 1'b1, 1'b1, 2'd2};
    tbl[4]  = '{4'b0000, 1'b1, 1'b1, 2'd3};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 2'd0};
    tbl[6]  = '{4'b0000, 1'b1, 1'b1, 2'd0};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 2'd1};
    tbl[8]  = '{4'b0000, 1'b1, 1'b1, 2'd2};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 2'd3};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 2'd0};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd0};

    @(negedge clk_96MHz);
    do_reset();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    chk("reset_ts", 64'(out_timestamp), 64'd0);
    chk("reset_id", 64'(out_sensor_id), 64'd0);
    chk("reset_ovr", 64'(overrun_flags), 64'd0);

    // Single event on channel 2
    decoded_data[2*DW +: DW] = 17'h1ABCD;
    timestamp_in[2*TW +: TW] = 24'h123456;
    data_availible = 4'b0100;
    tick();
    chk("t1_lat_valid", 64'(out_valid), 64'd0);
    data_availible = 4'b0000;
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_id", 64'(out_sensor_id), 64'd2);
    chk("t1_data", 64'(out_data), 64'h1ABCD);
    chk("t1_ts", 64'(out_timestamp), 64'h123456);
    chk("t1_ovr", 64'(overrun_flags), 64'd0);
    tick();
    chk("t1_drop", 64'(out_valid), 64'd0);

    // Table-driven round-robin burst
    do_reset();
    for (int r = 0; r < 12; r++) begin
      data_availible = tbl[r].da;
      out_ready      = tbl[r].rdy;
      tick();
      chk($sformatf("rr%0d_valid", r), 64'(out_valid), 64'(tbl[r].exp_valid));
      if (tbl[r].exp_valid) begin
        chk($sformatf("rr%0d_id", r), 64'(out_sensor_id), 64'(tbl[r].exp_id));
        chk($sformatf("rr%0d_data", r), 64'(out_data), 64'(def_data(int'(tbl[r].exp_id))));
        chk($sformatf("rr%0d_ts", r), 64'(out_timestamp), 64'(def_ts(int'(tbl[r].exp_id))));
      end
    end

    // Backpressure: ch1 presented and frozen while inputs wiggle
    do_reset();
    out_ready = 1'b0;
    data_availible = 4'b0110;
    tick();
    data_availible = 4'b0000;
    tick();
    chk("t3_valid", 64'(out_valid), 64'd1);
    chk("t3_id", 64'(out_sensor_id), 64'd1);
    frozen_data = def_data(1);
    frozen_ts   = def_ts(1);
    for (int c = 0; c < 10; c++) begin
      decoded_data  = {N*DW{1'b1}} ^ (N*DW)'(c * 32'h2345);
      timestamp_in  = (N*TW)'(c * 32'h5A5A5);
      clear_overrun = c[0];
      tick();
      chk($sformatf("t3_frz%0d", c),
          {23'd0, out_valid, out_sensor_id, out_data, out_timestamp},
          {23'd0, 1'b1, 2'd1, frozen_data, frozen_ts});
    end
    clear_overrun = 1'b0;
    set_defaults();
    out_ready = 1'b1;
    tick();
    chk("t3_next_valid", 64'(out_valid), 64'd1);
    chk("t3_next_id", 64'(out_sensor_id), 64'd2);
    chk("t3_next_data", 64'(out_data), 64'(def_data(2)));
    tick();
    chk("t3_empty", 64'(out_valid), 64'd0);

    // Overrun on ch3 while the output slot is blocked by ch0
    do_reset();
    out_ready = 1'b0;
    data_availible = 4'b0001;
    tick();
    data_availible = 4'b0000;
    tick();
    chk("t4_ch0_id", 64'(out_sensor_id), 64'd0);
    decoded_data[3*DW +: DW] = 17'h00001;
    data_availible = 4'b1000;
    tick();
    data_availible = 4'b0000;
    tick();
    chk("t4_no_ovr_yet", 64'(overrun_flags), 64'd0);
    decoded_data[3*DW +: DW] = 17'h00002;
    data_availible = 4'b1000;
    tick();
    chk("t4_ovr_set", 64'(overrun_flags), 64'b1000);
    data_availible = 4'b0000;
    out_ready = 1'b1;
    tick();
    chk("t4_ch3_valid", 64'(out_valid), 64'd1);
    chk("t4_ch3_id", 64'(out_sensor_id), 64'd3);
    chk("t4_ch3_data", 64'(out_data), 64'h00002);
    tick();
    chk("t4_only_one", 64'(out_valid), 64'd0);
    chk("t4_ovr_sticky", 64'(overrun_flags), 64'b1000);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("t4_ovr_clear", 64'(overrun_flags), 64'd0);

    // Held-high flag yields one capture only
    do_reset();
    cnt = 0;
    data_availible = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid && out_sensor_id == 2'd1) cnt++;
    end
    data_availible = 4'b0000;
    tick();
    chk("t5_count", 64'(cnt), 64'd1);

    // Reset mid-transfer discards output and pending events
    do_reset();
    out_ready = 1'b0;
    data_availible = 4'b0111;
    tick();
    data_availible = 4'b0000;
    tick();
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    chk("t6_pre_id", 64'(out_sensor_id), 64'd0);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_data", 64'(out_data), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("t6_nothing", 64'(cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
